sort_frame_loader: RTL and testbench
====================================

# sort_frame_loader

Upstream feeder for the odd-even nibble sorter. Accepts a stream of 4-bit elements over a valid/ready handshake and assembles them into one packed N-element frame in the sorter's bus format. Supports early termination of a frame by padding the unused slots. Holds the completed frame stable until the downstream consumer acknowledges it.

## Interface
Parameters:
- N, 10, elements per frame; legal range N >= 2.
- PAD, 4'hF, value placed in unfilled slots; 4'hF sorts to the tail of an ascending sort.
- CW, $clog2(N+1), width of `count`. Derived; do not override.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  4  element to load.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  loader can accept an element this cycle.
- flush  in  1  close the current partial frame.
- frame  out  [0:N*4-1]  packed frame. Element k is `frame[k*4 +: 4]`; element 0 is the first element received.
- frame_valid  out  1  `frame` is complete and stable.
- frame_ready  in  1  consumer accepts `frame`.
- count  out  CW  number of real (non-pad) elements in `frame`.

## Operation
- Two states: FILL and FULL. A write pointer `wp` (0..N-1) tracks the next slot to fill.
- Reset (`rst`=1 at an edge):
  - state FILL, `wp`=0, `count`=0, `frame_valid`=0.
  - Every slot of `frame` = PAD.
- FILL:
  - `in_ready`=1, `frame_valid`=0.
  - Accept: `in_valid`=1 at an edge writes `in_data` into slot `wp`, increments `wp`, increments `count`.
  - If the accepted element fills slot N-1, the next state is FULL.
  - Flush with data: `flush`=1 and `in_valid`=1 at the same edge. The element is accepted first, then the next state is FULL.
  - Flush without data: `flush`=1, `in_valid`=0, `wp`>0. Next state is FULL; remaining slots already hold PAD.
  - Flush on an empty frame (`flush`=1, `in_valid`=0, `wp`=0) is ignored and the state stays FILL.
- FULL:
  - `in_ready`=0, `frame_valid`=1. `frame` and `count` are frozen.
  - `in_valid` and `flush` are ignored.
  - `frame_ready`=1 at an edge releases the frame. Next state is FILL with `wp`=0, `count`=0, and every slot = PAD.
- `in_ready` and `frame_valid` are decoded from registered state only. There is no combinational path from any input to any output.
- `rst` has priority over every other input, including in the middle of a fill or during FULL. Any partial or held frame is discarded.

## Timing
- Accepting an element takes 1 cycle. The element is visible in `frame` the cycle after its accept edge.
- Frame completion: `frame_valid` rises the cycle after the edge that accepts element N-1 or performs the flush.
- `frame_valid` stays high until the edge where `frame_ready`=1. It falls in the following cycle.
- A release edge cannot also be an accept edge, because `in_ready`=0 throughout FULL. `in_ready` returns high in the cycle after release.
- Best-case throughput is N+1 cycles per full frame: N accepts plus 1 release cycle.
- `count` after a release or reset is 0. Its maximum is N.
- `wp` never wraps. Reaching slot N-1 forces FULL; `wp` cannot exceed N-1.

## Test plan
- Reset: drive `rst`=1 for 2 cycles, then 0.
  - Expect `frame_valid`=0, `in_ready`=1, `count`=0, all slots = 4'hF.
- Full frame (N=10): stream 9,8,...,0 back to back with `frame_ready`=0.
  - `frame_valid` rises one cycle after the 10th accept.
  - `frame` elements 0..9 = 9,8,...,0; `count`=10; `in_ready`=0.
- Backpressure: hold `frame_ready`=0 for 5 cycles while `in_valid`=1 with data 7.
  - `frame` and `count` unchanged; no element accepted.
  - Then pulse `frame_ready`=1 for one cycle: next cycle `frame_valid`=0, `in_ready`=1, `count`=0, all slots = F.
- Flush without data: send 3,1,2, then `flush`=1 with `in_valid`=0.
  - `frame` = 3,1,2,F,F,F,F,F,F,F; `count`=3.
- Flush with data, and empty flush:
  - After 4 elements, `flush`=1 with `in_valid`=1 and data 5: element 4 = 5, `count`=5, elements 5..9 = F.
  - With the loader empty, `flush`=1 alone: state stays FILL, `frame_valid` stays 0.
- Mid-fill reset: load 6 elements, assert `rst` for 1 cycle, then send 10 elements.
  - `frame_valid` rises only after all 10 post-reset elements are accepted.
  - `frame` contains only post-reset data; `count`=10.

Source files
------------

// File: rtl/sort_frame_loader.sv
// sort_frame_loader
// Collects a stream of 4-bit elements, arriving over a valid/ready handshake,
// into one packed N-element frame for the odd-even nibble sorter. A flush
// closes a partial frame early, and the unused slots keep PAD. A completed
// frame is held stable until the consumer accepts it.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   in_data      element to load
//   in_valid     in_data is valid
//   in_ready     loader can accept an element (registered)
//   flush        close the current partial frame
//   frame        packed frame, element k at frame[k*4 +: 4], element 0 first in
//   frame_valid  frame is complete and stable (registered)
//   frame_ready  consumer accepts frame
//   count        number of real (non-pad) elements in frame
module sort_frame_loader #(
    parameter int          N   = 10,
    parameter logic [3:0]  PAD = 4'hF,
    parameter int          CW  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [0:N*4-1]   frame,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CW-1:0]    count
);

    localparam int              WPW  = $clog2(N);
    localparam logic [WPW-1:0]  LAST = WPW'(N - 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t          state;
    logic [WPW-1:0]  wp;

    // in_ready and frame_valid are kept as registers that move together with
    // the state, so no input ever reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            wp          <= '0;
            count       <= '0;
            frame       <= {N{PAD}};
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            if (wp == WPW'(k))
                                frame[k*4 +: 4] <= in_data;
                        end
                        count <= count + CW'(1);
                        // The last slot or a flush closes the frame. wp is left
                        // where it is; the release rewinds it, so it never wraps.
                        if (wp == LAST || flush) begin
                            state       <= FULL;
                            in_ready    <= 1'b0;
                            frame_valid <= 1'b1;
                        end else begin
                            wp <= wp + WPW'(1);
                        end
                    end else if (flush && wp != '0) begin
                        // The remaining slots already hold PAD.
                        state       <= FULL;
                        in_ready    <= 1'b0;
                        frame_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (frame_ready) begin
                        state       <= FILL;
                        wp          <= '0;
                        count       <= '0;
                        frame       <= {N{PAD}};
                        in_ready    <= 1'b1;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready    <= 1'b1;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;

    localparam int N  = 10;
    localparam int CW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [0:N*4-1]  frame;
    logic            frame_valid;
    logic            frame_ready = 1'b0;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    sort_frame_loader #(.N(N), .PAD(4'hF)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .frame(frame),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is just the list of accepted elements plus a
    // "held" flag; everything not in the list reads as pad.
    int unsigned mq[$];
    bit          mfull;

    task automatic model_edge();
        if (rst) begin
            mq.delete();
            mfull = 0;
        end else if (mfull) begin
            if (frame_ready) begin
                mq.delete();
                mfull = 0;
            end
        end else begin
            if (in_valid) mq.push_back(int'(in_data));
            if (mq.size() == N || (flush && mq.size() > 0)) mfull = 1;
        end
    endtask

    function automatic logic [0:N*4-1] model_frame();
        logic [0:N*4-1] f;
        for (int k = 0; k < N; k++)
            f[k*4 +: 4] = (k < mq.size()) ? 4'(mq[k]) : 4'hF;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".frame"}, 64'(frame), 64'(model_frame()));
        chk({nm, ".count"}, 64'(count), 64'(mq.size()));
        chk({nm, ".in_ready"}, 64'(in_ready), 64'(!mfull));
        chk({nm, ".frame_valid"}, 64'(frame_valid), 64'(mfull));
    endtask

    // Apply the currently driven inputs across one rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic iv, input logic [3:0] d,
                         input logic fl, input logic fr);
        rst = r; in_valid = iv; in_data = d; flush = fl; frame_ready = fr;
    endtask

    typedef struct {
        logic           rst;
        logic           iv;
        logic [3:0]     d;
        logic           fl;
        logic           fr;
        logic           rdy;
        logic           fv;
        logic [3:0]     cnt;
        logic [0:N*4-1] frm;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic iv, logic [3:0] d, logic fl, logic fr,
                                logic rdy, logic fv, logic [3:0] cnt, logic [0:N*4-1] frm);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.fl = fl; v.fr = fr;
        v.rdy = rdy; v.fv = fv; v.cnt = cnt; v.frm = frm;
        vecs.push_back(v);
    endfunction

    initial begin
        // reset for two cycles
        add(1,0,0,0,0, 1,0, 0, 40'hFFFFFFFFFF);
        add(1,0,0,0,0, 1,0, 0, 40'hFFFFFFFFFF);
        // full frame 9..0
        add(0,1,9,0,0, 1,0, 1, 40'h9FFFFFFFFF);
        add(0,1,8,0,0, 1,0, 2, 40'h98FFFFFFFF);
        add(0,1,7,0,0, 1,0, 3, 40'h987FFFFFFF);
        add(0,1,6,0,0, 1,0, 4, 40'h9876FFFFFF);
        add(0,1,5,0,0, 1,0, 5, 40'h98765FFFFF);
        add(0,1,4,0,0, 1,0, 6, 40'h987654FFFF);
        add(0,1,3,0,0, 1,0, 7, 40'h9876543FFF);
        add(0,1,2,0,0, 1,0, 8, 40'h98765432FF);
        add(0,1,1,0,0, 1,0, 9, 40'h987654321F);
        add(0,1,0,0,0, 0,1,10, 40'h9876543210);
        // backpressure: data 7 offered while held, plus a flush that must be ignored
        for (int i = 0; i < 5; i++)
            add(0,1,7,(i == 2),0, 0,1,10, 40'h9876543210);
        // release
        add(0,0,0,0,1, 1,0, 0, 40'hFFFFFFFFFF);
        // flush without data
        add(0,1,3,0,0, 1,0, 1, 40'h3FFFFFFFFF);
        add(0,1,1,0,0, 1,0, 2, 40'h31FFFFFFFF);
        add(0,1,2,0,0, 1,0, 3, 40'h312FFFFFFF);
        add(0,0,0,1,0, 0,1, 3, 40'h312FFFFFFF);
        add(0,0,0,0,0, 0,1, 3, 40'h312FFFFFFF);
        add(0,0,0,0,1, 1,0, 0, 40'hFFFFFFFFFF);
        // flush with data
        add(0,1,1,0,0, 1,0, 1, 40'h1FFFFFFFFF);
        add(0,1,2,0,0, 1,0, 2, 40'h12FFFFFFFF);
        add(0,1,3,0,0, 1,0, 3, 40'h123FFFFFFF);
        add(0,1,4,0,0, 1,0, 4, 40'h1234FFFFFF);
        add(0,1,5,1,0, 0,1, 5, 40'h12345FFFFF);
        add(0,0,0,0,1, 1,0, 0, 40'hFFFFFFFFFF);
        // empty flush is ignored
        add(0,0,0,1,0, 1,0, 0, 40'hFFFFFFFFFF);
        add(0,0,0,1,0, 1,0, 0, 40'hFFFFFFFFFF);
        // release attempt while filling does nothing
        add(0,0,0,0,1, 1,0, 0, 40'hFFFFFFFFFF);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].fr);
            step();
            chk($sformatf("vec%0d.frame", i), 64'(frame), 64'(vecs[i].frm));
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
            chk($sformatf("vec%0d.frame_valid", i), 64'(frame_valid), 64'(vecs[i].fv));
        end

        // mid-fill reset: 6 elements, 1-cycle reset, then 10 new elements
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 4'(i + 1), 0, 0);
            step();
        end
        chk("midrst.pre_count", 64'(count), 64'd6);
        drive(1, 1, 4'hA, 0, 0);
        step();
        chk_model("midrst.after_rst");
        chk("midrst.rst_frame", 64'(frame), 64'(40'hFFFFFFFFFF));
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 4'((i * 3) & 4'hF), 0, 0);
            step();
            chk($sformatf("midrst.fv%0d", i), 64'(frame_valid), 64'(i == 9));
        end
        chk("midrst.frame", 64'(frame), 64'(40'h0369CF258B));
        chk("midrst.count", 64'(count), 64'd10);
        drive(0, 0, 0, 0, 1);
        step();
        chk_model("midrst.release");

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 70),
                  4'($urandom),
                  ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 30));
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
